// File: rtl/iobus_pkg.sv
// Shared IOBUS address map: default base addresses, status/clear words,
// register address step, and a helper that forms per-register addresses.
package iobus_pkg;

  localparam logic [31:0] IOBUS_IN_BASE   = 32'h1100_8000;
  localparam logic [31:0] IOBUS_OUT_BASE  = 32'h1100_C000;
  localparam logic [31:0] IOBUS_STAT_ADDR = 32'h1100_C0F8;
  localparam logic [31:0] IOBUS_ICLR_ADDR = 32'h1100_C0FC;
  localparam int          IOBUS_STEP      = 4;

  function automatic logic [31:0] port_addr(
    input logic [31:0] base,
    input int          idx
  );
    return base + 32'(IOBUS_STEP * idx);
  endfunction

endpackage

// File: rtl/iobus_debounce.sv
// One-bit 2-flop synchroniser plus stability-counter debouncer.
// Ports: i_clk, i_rst_n (async low), i_raw (async input), o_db (debounced).
module iobus_debounce #(
  parameter int DB_CYCLES = 2000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_db
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  // r_s3 holds last cycle's synchronised value so any
  // glitch restarts the stability count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_s2 == r_db || r_s2 != r_s3) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/iobus_io_hub.sv
// MCU IOBUS hub: debounced input ports, writable output registers,
// edge interrupt with status/clear words, combinational read mux.
// Ports: clk, RST_N, IOBUS_addr/out/wr/in, raw_in, out_regs, intr.
module iobus_io_hub
  import iobus_pkg::*;
#(
  parameter int          IN_PORTS  = 2,
  parameter int          OUT_PORTS = 3,
  parameter int          IN_W      = 16,
  parameter int          DB_CYCLES = 2000,
  parameter logic [31:0] IN_BASE   = IOBUS_IN_BASE,
  parameter logic [31:0] OUT_BASE  = IOBUS_OUT_BASE,
  parameter logic [31:0] STAT_ADDR = IOBUS_STAT_ADDR,
  parameter logic [31:0] ICLR_ADDR = IOBUS_ICLR_ADDR,
  parameter int          INTR_PORT = 0,
  parameter int          INTR_BIT  = 4
) (
  input  logic                      clk,
  input  logic                      RST_N,
  input  logic [31:0]               IOBUS_addr,
  input  logic [31:0]               IOBUS_out,
  input  logic                      IOBUS_wr,
  output logic [31:0]               IOBUS_in,
  input  logic [IN_PORTS*IN_W-1:0]  raw_in,
  output logic [OUT_PORTS*32-1:0]   out_regs,
  output logic                      intr
);

  localparam int NB   = IN_PORTS * IN_W;
  localparam int IBIT = INTR_PORT * IN_W + INTR_BIT;

  logic [NB-1:0]          w_db;
  logic [OUT_PORTS*32-1:0] r_out;
  logic                   r_src_prev;
  logic                   r_pend;
  logic                   w_rise;
  logic                   w_clr;
  logic [31:0]            w_rd;

  for (genvar g = 0; g < NB; g++) begin : g_db
    iobus_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .i_clk  (clk),
      .i_rst_n(RST_N),
      .i_raw  (raw_in[g]),
      .o_db   (w_db[g])
    );
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_out <= '0;
    end else if (IOBUS_wr) begin
      for (int j = 0; j < OUT_PORTS; j++) begin
        if (IOBUS_addr == port_addr(OUT_BASE, j)) begin
          r_out[j*32 +: 32] <= IOBUS_out;
        end
      end
    end
  end

  // Both edge-detect flops reset to 0 with the debouncer,
  // so leaving reset never looks like a rising edge.
  assign w_rise = w_db[IBIT] & ~r_src_prev;
  assign w_clr  = IOBUS_wr && (IOBUS_addr == ICLR_ADDR);

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_src_prev <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_src_prev <= w_db[IBIT];
      r_pend     <= w_rise | (r_pend & ~w_clr);
    end
  end

  always_comb begin
    w_rd = '0;
    if (IOBUS_addr[1:0] == 2'b00) begin
      for (int i = 0; i < IN_PORTS; i++) begin
        if (IOBUS_addr == port_addr(IN_BASE, i)) begin
          w_rd = 32'(w_db[i*IN_W +: IN_W]);
        end
      end
      for (int j = 0; j < OUT_PORTS; j++) begin
        if (IOBUS_addr == port_addr(OUT_BASE, j)) begin
          w_rd = r_out[j*32 +: 32];
        end
      end
      if (IOBUS_addr == STAT_ADDR) begin
        w_rd = {31'b0, r_pend};
      end
    end
  end

  assign IOBUS_in = w_rd;
  assign out_regs = r_out;
  assign intr     = r_pend;

endmodule

// File: tb/tb_iobus_io_hub.sv
// Self-checking bench for iobus_io_hub with DB_CYCLES=4: history-based
// reference model compared every cycle, plus directed literal checks.
module tb_iobus_io_hub;
  import iobus_pkg::*;

  localparam int INP  = 2;
  localparam int OUTP = 3;
  localparam int W    = 16;
  localparam int DB   = 4;
  localparam int NB   = INP * W;
  localparam int IB   = 0 * W + 4;
  localparam logic [31:0] INB  = IOBUS_IN_BASE;
  localparam logic [31:0] OUTB = IOBUS_OUT_BASE;
  localparam logic [31:0] STAT = IOBUS_STAT_ADDR;
  localparam logic [31:0] ICLR = IOBUS_ICLR_ADDR;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [31:0]       addr  = '0;
  logic [31:0]       wdata = '0;
  logic              wr    = 1'b0;
  logic [31:0]       rdata;
  logic [NB-1:0]     raw   = '0;
  logic [OUTP*32-1:0] oregs;
  logic              intr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iobus_io_hub #(
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .RST_N     (rst_n),
    .IOBUS_addr(addr),
    .IOBUS_out (wdata),
    .IOBUS_wr  (wr),
    .IOBUS_in  (rdata),
    .raw_in    (raw),
    .out_regs  (oregs),
    .intr      (intr)
  );

  // Model: a bit's debounced value becomes v once the DB+1 raw samples
  // taken 2..DB+2 edges ago all equal v (two sync stages, then a run).
  logic [NB-1:0] m_hist [0:DB+2];
  logic [NB-1:0] m_db;
  logic          m_rise;
  logic          m_pend;
  logic [31:0]   m_out [OUTP];
  logic [NB-1:0] all1, all0;

  task automatic m_reset();
    for (int k = 0; k <= DB + 2; k++) m_hist[k] = '0;
    m_db   = '0;
    m_rise = 1'b0;
    m_pend = 1'b0;
    for (int j = 0; j < OUTP; j++) m_out[j] = '0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        if (wr) begin
          for (int j = 0; j < OUTP; j++)
            if (addr == OUTB + 32'(4 * j)) m_out[j] = wdata;
        end
        m_pend = m_rise | (m_pend & !(wr && addr == ICLR));
        for (int k = DB + 2; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = raw;
        all1 = '1;
        all0 = '1;
        for (int k = 2; k <= DB + 2; k++) begin
          all1 = all1 & m_hist[k];
          all0 = all0 & ~m_hist[k];
        end
        m_rise = ~m_db[IB] & all1[IB];
        m_db   = (m_db | all1) & ~all0;
      end
    end
  end

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[1:0] == 2'b00) begin
      for (int i = 0; i < INP; i++)
        if (a == INB + 32'(4 * i)) r = 32'(m_db[i*W +: W]);
      for (int j = 0; j < OUTP; j++)
        if (a == OUTB + 32'(4 * j)) r = m_out[j];
      if (a == STAT) r = {31'b0, m_pend};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int j = 0; j < OUTP; j++)
        chk("model out_reg", oregs[j*32 +: 32], m_out[j]);
      chk("model intr", 32'(intr), 32'(m_pend));
      chk("model rdata", rdata, m_rd(addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst out0", oregs[31:0], 32'h0);
    chk("rst out2", oregs[95:64], 32'h0);
    chk("rst intr", 32'(intr), 32'h0);
    chk("rst rd", rdata, 32'h0);
    rst_n = 1'b1;

    // step on port 0 qualifies exactly 6 edges after first sample
    addr = INB;
    raw[15:0] = 16'h00A5;
    repeat (6) tick();
    chk("in0 early", rdata, 32'h0);
    tick();
    chk("in0 qual", rdata, 32'h0000_00A5);

    // 3-cycle glitch on interrupt bit is filtered
    raw[15:0] = 16'h00B5;
    repeat (3) tick();
    raw[15:0] = 16'h00A5;
    repeat (10) tick();
    chk("glitch rd", rdata, 32'h0000_00A5);
    chk("glitch intr", 32'(intr), 32'h0);

    // held edge raises pending one cycle after debounce
    raw[15:0] = 16'h00B5;
    repeat (7) tick();
    chk("held rd", rdata, 32'h0000_00B5);
    chk("held intr0", 32'(intr), 32'h0);
    tick();
    chk("held intr1", 32'(intr), 32'h1);
    addr = STAT;
    #1 chk("stat set", rdata, 32'h1);
    addr = ICLR;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    chk("iclr", 32'(intr), 32'h0);
    raw[15:0] = 16'h00A5;
    repeat (12) tick();
    chk("fall intr", 32'(intr), 32'h0);

    // output register write, misaligned write ignored
    addr  = OUTB + 32'd8;
    wdata = 32'hDEAD_BEEF;
    wr    = 1'b1;
    tick();
    wr = 1'b0;
    chk("out2 wr", oregs[95:64], 32'hDEAD_BEEF);
    #1 chk("out2 rd", rdata, 32'hDEAD_BEEF);
    addr  = OUTB + 32'd2;
    wdata = 32'h1234_5678;
    wr    = 1'b1;
    tick();
    wr = 1'b0;
    chk("mis out0", oregs[31:0], 32'h0);
    chk("mis out1", oregs[63:32], 32'h0);
    chk("mis out2", oregs[95:64], 32'hDEAD_BEEF);
    chk("mis rd", rdata, 32'h0);
    addr  = OUTB;
    wdata = 32'hCAFE_0001;
    wr    = 1'b1;
    tick();
    wr = 1'b0;
    chk("out0 wr", oregs[31:0], 32'hCAFE_0001);

    // clear on the same edge that sets: set wins
    raw[15:0] = 16'h00B5;
    repeat (7) tick();
    addr = ICLR;
    wr   = 1'b1;
    tick();
    wr = 1'b0;
    chk("set+clr intr", 32'(intr), 32'h1);
    addr = STAT;
    #1 chk("set+clr stat", rdata, 32'h1);

    // reset mid-debounce discards partial count
    raw[31:16] = 16'h1234;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid rst out0", oregs[31:0], 32'h0);
    chk("mid rst out2", oregs[95:64], 32'h0);
    chk("mid rst intr", 32'(intr), 32'h0);
    tick();
    rst_n = 1'b1;
    addr  = INB + 32'd4;
    repeat (6) tick();
    chk("requal early", rdata, 32'h0);
    tick();
    chk("requal", rdata, 32'h0000_1234);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
